// File: rtl/fpu_mult_issue.sv
// rtl/fpu_mult_issue.sv - operand FIFO, single-outstanding issue FSM and result capture
// for the 5-cycle FP16 multiplier, with a watchdog on lost results.
module fpu_mult_issue #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        flush,
  output logic        mul_valid_in,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_valid_out,
  input  logic [15:0] mul_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        busy,
  output logic        timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          drop_q, drop_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_result_q, out_result_d;
  logic          timeout_err_q, timeout_err_d;

  logic slot_free, issue, push;

  assign slot_free    = !out_valid_q || out_ready;
  assign in_ready     = (count_q != DEPTH_C);
  assign push         = in_valid && in_ready && !flush;
  assign issue        = (state_q == IDLE) && (count_q != '0) && slot_free && !flush;
  assign mul_valid_in = issue;
  assign mul_a        = mem_q[rd_ptr_q][31:16];
  assign mul_b        = mem_q[rd_ptr_q][15:0];
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign busy         = (state_q == WAIT);
  assign timeout_err  = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wait_cnt_d    = wait_cnt_q;
    drop_d        = drop_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    timeout_err_d = timeout_err_q;

    if (push) begin
      mem_d[wr_ptr_q] = {in_a, in_b};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !issue) begin
      count_d = count_q + CW'(1);
    end else if (!push && issue) begin
      count_d = count_q - CW'(1);
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (mul_valid_out) begin
          if (!drop_q && !flush) begin
            out_valid_d  = 1'b1;
            out_result_d = mul_result;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          timeout_err_d = 1'b1;
          drop_d        = 1'b0;
          state_d       = IDLE;
        end else if (flush) begin
          // Result still in flight: remember to discard it when it lands.
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      wr_ptr_d    = rd_ptr_q;
      count_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wait_cnt_q    <= '0;
      drop_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wait_cnt_q    <= wait_cnt_d;
      drop_q        <= drop_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      timeout_err_q <= timeout_err_d;
    end
  end
endmodule

// File: tb/tb_fpu_mult_issue.sv
// tb/tb_fpu_mult_issue.sv - scoreboard bench for fpu_mult_issue against a
// behavioural 5-cycle FP16 multiplier.
module tb_fpu_mult_issue;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic        flush = 1'b0;
  logic        mul_valid_in;
  logic [15:0] mul_a, mul_b;
  logic        mul_valid_out;
  logic [15:0] mul_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int issue_cnt = 0;
  logic [15:0] exp_q[$];
  int rise_q[$];
  logic prev_ov = 1'b0;
  logic suppress = 1'b0;

  fpu_mult_issue #(.DEPTH(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .flush(flush), .mul_valid_in(mul_valid_in),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid_out(mul_valid_out),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Normal-operand FP16 product, truncated; exact for the operands used here.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] m;
    int e;
    m = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (m[21]) return {a[15] ^ b[15], 5'(e + 1), m[20:11]};
    return {a[15] ^ b[15], 5'(e), m[19:10]};
  endfunction

  logic [4:0]  pv = '0;
  logic [15:0] pr [5];
  always @(posedge clk) begin
    pv    <= {pv[3:0], mul_valid_in};
    pr[0] <= fp16_mul(mul_a, mul_b);
    for (int i = 1; i < 5; i++) pr[i] <= pr[i-1];
  end
  assign mul_valid_out = pv[4] && !suppress;
  assign mul_result    = pr[4];

  always @(negedge clk) begin
    if (mul_valid_in) issue_cnt <= issue_cnt + 1;
    if (out_valid && !prev_ov) rise_q.push_back(cyc);
    prev_ov <= out_valid;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got result %h, required none", out_result);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_result !== e) begin
          failures++;
          $display("FAIL sb_result: got %h, required %h", out_result, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e, input bit track);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    if (track && in_ready) exp_q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    logic [52:0] got;
    #2;
    got = {in_ready, mul_valid_in, mul_a, mul_b, out_valid, out_result, busy, timeout_err};
    checks++;
    if (got !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got %h, required %h", got,
               {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int c0;
    bit ok;
    out_ready = 1'b1;
    rise_q.delete();
    push_op(16'h3C00, 16'h4000, 16'h4000, 1'b1);
    c0 = cyc;
    checks++;
    if (mul_valid_in !== 1'b1) begin
      failures++;
      $display("FAIL single_issue: mul_valid_in=%b, required 1", mul_valid_in);
    end
    step();
    checks++;
    if ({mul_valid_in, busy} !== 2'b01) begin
      failures++;
      $display("FAIL single_strobe: {mul_valid_in,busy}=%b, required 01", {mul_valid_in, busy});
    end
    wait_out(ok);
    checks++;
    if (!ok || cyc - c0 != 6) begin
      failures++;
      $display("FAIL single_latency: ok=%0d latency=%0d, required 6", ok, cyc - c0);
    end
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    out_ready = 1'b1;
    rise_q.delete();
    push_op(16'h4000, 16'h4200, 16'h4600, 1'b1);
    push_op(16'h3C00, 16'hBC00, 16'hBC00, 1'b1);
    push_op(16'h4000, 16'h4000, 16'h4400, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full: in_ready=%b, required 0", in_ready);
    end
    repeat (25) step();
    checks++;
    if (rise_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: results=%0d, required 3", rise_q.size());
    end else begin
      checks++;
      if (rise_q[1] - rise_q[0] != 6 || rise_q[2] - rise_q[1] != 6) begin
        failures++;
        $display("FAIL b2b_spacing: gaps %0d,%0d, required 6,6",
                 rise_q[1] - rise_q[0], rise_q[2] - rise_q[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int i0;
    bit ok, unstable;
    out_ready = 1'b0;
    i0 = issue_cnt;
    push_op(16'h4000, 16'h4000, 16'h4400, 1'b1);
    push_op(16'h4200, 16'h4200, 16'h4880, 1'b1);
    wait_out(ok);
    unstable = !ok;
    repeat (8) begin
      step();
      if (out_valid !== 1'b1 || out_result !== 16'h4400) unstable = 1'b1;
    end
    checks++;
    if (issue_cnt - i0 != 1) begin
      failures++;
      $display("FAIL bp_one_issue: issues=%0d, required 1", issue_cnt - i0);
    end
    checks++;
    if (unstable) begin
      failures++;
      $display("FAIL bp_hold: out_valid=%b out_result=%h, required 1 and 4400", out_valid, out_result);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (mul_valid_in !== 1'b1) begin
      failures++;
      $display("FAIL bp_reissue: mul_valid_in=%b, required 1", mul_valid_in);
    end
    step();
    out_ready = 1'b0;
    wait_out(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_second: out_valid=%b, required 1", out_valid);
    end
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_flush();
    int i0, r0;
    bit ok;
    out_ready = 1'b1;
    rise_q.delete();
    push_op(16'h4000, 16'h4000, 16'h4400, 1'b0);
    push_op(16'h4200, 16'h4200, 16'h4880, 1'b0);
    step();
    i0 = issue_cnt;
    r0 = rise_q.size();
    flush = 1'b1;
    in_valid = 1'b1;
    in_a = 16'h4200;
    in_b = 16'h4000;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (12) step();
    checks++;
    if (rise_q.size() != r0 || issue_cnt != i0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop: results=%0d issues=%0d busy=%b, required 0 0 0",
               rise_q.size() - r0, issue_cnt - i0, busy);
    end
    push_op(16'h3C00, 16'h4000, 16'h4000, 1'b1);
    wait_out(ok);
    step();
    checks++;
    if (!ok || rise_q.size() != r0 + 1) begin
      failures++;
      $display("FAIL flush_after: results=%0d, required 1", rise_q.size() - r0);
    end
  endtask

  task automatic test_timeout();
    int c0, n;
    bit ok;
    out_ready = 1'b1;
    suppress = 1'b1;
    push_op(16'h4000, 16'h4000, 16'h4400, 1'b0);
    c0 = cyc;
    push_op(16'h4200, 16'h4000, 16'h4600, 1'b1);
    n = 0;
    while (!timeout_err && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (timeout_err !== 1'b1 || cyc - c0 != TIMEOUT + 2) begin
      failures++;
      $display("FAIL to_fire: timeout_err=%b at %0d cycles, required 1 at %0d",
               timeout_err, cyc - c0, TIMEOUT + 2);
    end
    checks++;
    if ({busy, mul_valid_in} !== 2'b01) begin
      failures++;
      $display("FAIL to_idle: {busy,mul_valid_in}=%b, required 01", {busy, mul_valid_in});
    end
    suppress = 1'b0;
    wait_out(ok);
    repeat (5) step();
    checks++;
    if (!ok || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky: ok=%0d timeout_err=%b, required 1 1", ok, timeout_err);
    end
  endtask

  task automatic test_async_reset();
    logic [52:0] got;
    int i0, r0;
    out_ready = 1'b1;
    push_op(16'h4000, 16'h4200, 16'h4600, 1'b0);
    push_op(16'h4000, 16'h4000, 16'h4400, 1'b0);
    step();
    #3;
    rst = 1'b1;
    #1;
    got = {in_ready, mul_valid_in, mul_a, mul_b, out_valid, out_result, busy, timeout_err};
    checks++;
    if (got !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL arst_values: got %h, required %h", got,
               {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0});
    end
    step();
    rst = 1'b0;
    i0 = issue_cnt;
    r0 = rise_q.size();
    repeat (10) step();
    checks++;
    if (rise_q.size() != r0 || issue_cnt != i0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL arst_stray: results=%0d issues=%0d timeout_err=%b, required 0 0 0",
               rise_q.size() - r0, issue_cnt - i0, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_timeout();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
